// File: rtl/bilinear_req_scheduler.sv
// Bilinear read-path request sequencer: raster-walks the output image, maps each
// output pixel to a Q16.8 source position and issues one tap request per pixel.
module bilinear_req_scheduler #(
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned IMG_HEIGHT = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_out_w,
  input  logic [15:0] cfg_out_h,
  input  logic [15:0] cfg_step_x,
  input  logic [15:0] cfg_step_y,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_xi_base,
  output logic [15:0] req_yi_base,
  output logic [7:0]  req_fx_q,
  output logic [7:0]  req_fy_q,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic        busy,
  output logic        done,
  output logic [31:0] stall_cnt
);

  localparam int unsigned IW = ACC_W - 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      out_w_q, out_w_d, out_h_q, out_h_d;
  logic [15:0]      step_x_q, step_x_d, step_y_q, step_y_d;
  logic [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [15:0]      ox_q, ox_d, oy_q, oy_d;
  logic [31:0]      stall_q, stall_d;

  logic             row_end, last_pix;
  logic [IW-1:0]    xi_raw, yi_raw;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      out_w_q  <= '0;
      out_h_q  <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_w_q  <= out_w_d;
      out_h_q  <= out_h_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      stall_q  <= stall_d;
    end
  end

  assign row_end  = (ox_q == out_w_q - 16'd1);
  assign last_pix = row_end && (oy_q == out_h_q - 16'd1);

  // Next-state: job start/config latch, raster advance on handshake, stall counting.
  always_comb begin
    state_d  = state_q;
    out_w_d  = out_w_q;
    out_h_d  = out_h_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    stall_d  = stall_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          out_w_d  = cfg_out_w;
          out_h_d  = cfg_out_h;
          step_x_d = cfg_step_x;
          step_y_d = cfg_step_y;
          acc_x_d  = '0;
          acc_y_d  = '0;
          ox_d     = '0;
          oy_d     = '0;
          stall_d  = '0;
          state_d  = (cfg_out_w == 16'd0 || cfg_out_h == 16'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!req_ready && stall_q != '1) stall_d = stall_q + 32'd1;
        // Abort takes priority: a same-cycle handshake is accepted but no successor is prepared.
        if (abort) begin
          state_d = S_IDLE;
        end else if (req_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else if (row_end) begin
            acc_x_d = '0;
            ox_d    = '0;
            acc_y_d = acc_y_q + ACC_W'(step_y_q);
            oy_d    = oy_q + 16'd1;
          end else begin
            acc_x_d = acc_x_q + ACC_W'(step_x_q);
            ox_d    = ox_q + 16'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Source-coordinate mapping with edge clamp so the right/bottom tap stays in range.
  always_comb begin
    xi_raw = acc_x_q[ACC_W-1:8];
    yi_raw = acc_y_q[ACC_W-1:8];
    if (xi_raw >= IW'(IMG_WIDTH - 1)) begin
      req_xi_base = 16'(IMG_WIDTH - 2);
      req_fx_q    = '1;
    end else begin
      req_xi_base = 16'(xi_raw);
      req_fx_q    = acc_x_q[7:0];
    end
    if (yi_raw >= IW'(IMG_HEIGHT - 1)) begin
      req_yi_base = 16'(IMG_HEIGHT - 2);
      req_fy_q    = '1;
    end else begin
      req_yi_base = 16'(yi_raw);
      req_fy_q    = acc_y_q[7:0];
    end
  end

  assign req_valid = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_bilinear_req_scheduler.sv
// Directed bench for bilinear_req_scheduler: a 4x4-image and a 16x16-image instance
// share stimulus; checks address the instance selected by img.
module tb_bilinear_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, req_ready;
  logic [15:0] cfg_out_w, cfg_out_h, cfg_step_x, cfg_step_y;

  logic        v4, b4, d4, v16, b16, d16;
  logic [15:0] xi4, yi4, ox4, oy4, xi16, yi16, ox16, oy16;
  logic [7:0]  fx4, fy4, fx16, fy16;
  logic [31:0] sc4, sc16;

  logic        t_valid, t_busy, t_done;
  logic [15:0] t_xi, t_yi, t_ox, t_oy;
  logic [7:0]  t_fx, t_fy;
  logic [31:0] t_sc;

  int img = 4;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bilinear_req_scheduler #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .ACC_W(24)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .req_valid(v4), .req_ready(req_ready), .req_xi_base(xi4), .req_yi_base(yi4),
    .req_fx_q(fx4), .req_fy_q(fy4), .out_x(ox4), .out_y(oy4),
    .busy(b4), .done(d4), .stall_cnt(sc4));

  bilinear_req_scheduler #(.IMG_WIDTH(16), .IMG_HEIGHT(16), .ACC_W(24)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .req_valid(v16), .req_ready(req_ready), .req_xi_base(xi16), .req_yi_base(yi16),
    .req_fx_q(fx16), .req_fy_q(fy16), .out_x(ox16), .out_y(oy16),
    .busy(b16), .done(d16), .stall_cnt(sc16));

  always_comb begin
    if (img == 4) begin
      t_valid = v4;  t_busy = b4;  t_done = d4;  t_xi = xi4;  t_yi = yi4;
      t_fx = fx4;    t_fy = fy4;   t_ox = ox4;   t_oy = oy4;  t_sc = sc4;
    end else begin
      t_valid = v16; t_busy = b16; t_done = d16; t_xi = xi16; t_yi = yi16;
      t_fx = fx16;   t_fy = fy16;  t_ox = ox16;  t_oy = oy16; t_sc = sc16;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Reference mapping: position = index*step, integer/fraction split, clamp at edge.
  function automatic logic [23:0] map_tap(input int idx, input int step, input int dim);
    int pos, ip;
    pos = idx * step;
    ip  = pos >> 8;
    if (ip >= dim - 1) return {16'(dim - 2), 8'hFF};
    return {16'(ip), 8'(pos & 255)};
  endfunction

  // mode 0: ready always high; mode 1: ready pattern 1-0-0 repeating.
  task automatic run_job(input int w, input int h, input logic [15:0] sx, input logic [15:0] sy,
                         input int mode, input int abort_after, input bit inject);
    int ex = 0, ey = 0, acc_cnt = 0, stalls = 0, cyc = 0;
    bit fin = 0;
    logic [23:0] tx, ty;
    @(negedge clk);
    cfg_out_w = 16'(w); cfg_out_h = 16'(h); cfg_step_x = sx; cfg_step_y = sy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Config is junk from here on; the running job must ignore it.
    cfg_out_w = 16'd2; cfg_out_h = 16'd2; cfg_step_x = 16'h0300; cfg_step_y = 16'h0300;
    check("busy_after_start", 64'(t_busy), 64'd1);
    check("stall_clr", 64'(t_sc), 64'd0);
    while (!fin) begin
      start = inject && (cyc == 2);
      req_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (abort_after != 0 && acc_cnt == abort_after) begin
        abort = 1'b1;
        req_ready = 1'b0;
      end
      #1;
      check("req_valid", 64'(t_valid), 64'd1);
      tx = map_tap(ex, int'(sx), img);
      ty = map_tap(ey, int'(sy), img);
      check("pos", 64'({t_ox, t_oy}), 64'({16'(ex), 16'(ey)}));
      check("tap", 64'({t_xi, t_fx, t_yi, t_fy}), 64'({tx, ty}));
      if (img == 16 && sx == 16'h0080 && ey == 0 && req_ready) begin
        if (ex == 1)  check("x_ox1",  64'({t_xi, t_fx}), 64'h00_0080);
        if (ex == 3)  check("x_ox3",  64'({t_xi, t_fx}), 64'h00_0180);
        if (ex == 30) check("x_ox30", 64'({t_xi, t_fx}), 64'h00_0EFF);
      end
      if (img == 16 && sy == 16'h0080 && ey == 31 && ex == 0 && req_ready)
        check("y_row31", 64'({t_yi, t_fy}), 64'h00_0EFF);
      if (!req_ready) stalls++;
      else begin
        acc_cnt++;
        ex++;
        if (ex == w) begin ex = 0; ey++; end
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        check("abort_valid", 64'(t_valid), 64'd0);
        check("abort_busy", 64'(t_busy), 64'd0);
        check("abort_done", 64'(t_done), 64'd0);
        fin = 1;
      end else if (acc_cnt == w * h) begin
        check("done_pulse", 64'(t_done), 64'd1);
        check("valid_drop", 64'(t_valid), 64'd0);
        @(negedge clk);
        check("done_clear", 64'(t_done), 64'd0);
        check("busy_clear", 64'(t_busy), 64'd0);
        fin = 1;
      end else if (cyc > 5000) begin
        check("timeout", 64'd0, 64'd1);
        fin = 1;
      end
    end
    req_ready = 1'b1;
    check("accepts", 64'(acc_cnt), 64'(abort_after != 0 ? abort_after : w * h));
    check("stall_cnt", 64'(t_sc), 64'(stalls));
  endtask

  initial begin
    int dones, vals;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; req_ready = 1'b1;
    cfg_out_w = '0; cfg_out_h = '0; cfg_step_x = '0; cfg_step_y = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", 64'({t_valid, t_busy, t_done, t_sc}), 64'd0);
    check("rst_coords", 64'({t_xi, t_yi, t_fx, t_fy}), 64'd0);
    rst_n = 1'b1;

    // 4x4 image, 4x4 out, unit step, with a stray start during ISSUE.
    img = 4;
    run_job(4, 4, 16'h0100, 16'h0100, 0, 0, 1'b1);

    // 16x16 image, 32x32 out, half step, with edge clamp.
    img = 16;
    run_job(32, 32, 16'h0080, 16'h0080, 0, 0, 1'b0);

    // Backpressure 1-0-0.
    run_job(5, 3, 16'h0140, 16'h0200, 1, 0, 1'b0);

    // Zero-width job: no requests, one done pulse.
    @(negedge clk);
    cfg_out_w = 16'd0; cfg_out_h = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; vals = 0;
    for (int i = 0; i < 4; i++) begin
      if (t_done) dones++;
      if (t_valid) vals++;
      @(negedge clk);
    end
    check("zero_done", 64'(dones), 64'd1);
    check("zero_valid", 64'(vals), 64'd0);

    // Abort after 5 accepts (with stall in the abort cycle), then restart cleanly.
    run_job(4, 4, 16'h0100, 16'h0100, 0, 5, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_ign", 64'(t_busy), 64'd0);
    run_job(4, 4, 16'h0100, 16'h0100, 0, 0, 1'b0);

    // Reset mid-row.
    @(negedge clk);
    cfg_out_w = 16'd8; cfg_out_h = 16'd2; cfg_step_x = 16'h0100; cfg_step_y = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_ox", 64'(t_ox), 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_outs", 64'({t_valid, t_busy, t_done, t_sc}), 64'd0);
    check("mid_rst_pos", 64'({t_ox, t_oy, t_xi, t_fx}), 64'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      if (t_done) dones++;
      @(negedge clk);
    end
    check("mid_rst_nodone", 64'(dones), 64'd0);
    run_job(8, 2, 16'h0180, 16'h0100, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
